// File: rtl/sm4_pkg.sv
// Shared constants and types for the SM4 block assembler: beat/block geometry,
// FIFO entry flag positions and the collector state encoding.
`ifndef IO_WIDTH
`define IO_WIDTH 32
`endif

package sm4_pkg;

    localparam int unsigned IO_WIDTH    = `IO_WIDTH;
    localparam int unsigned BLOCK_WIDTH = 128;
    localparam int unsigned BEATS       = BLOCK_WIDTH / IO_WIDTH;
    localparam int unsigned CNT_W       = $clog2(BEATS) + 1;
    localparam int unsigned ENTRY_W     = IO_WIDTH + 2;
    localparam int unsigned SOF_BIT     = IO_WIDTH + 1;
    localparam int unsigned KEY_BIT     = IO_WIDTH;

    typedef enum logic {
        COLLECT = 1'b0,
        OUT     = 1'b1
    } state_e;

    // Beat k lands MSB-first: beat 0 occupies the top IO_WIDTH bits.
    function automatic int unsigned slot_lsb(input int unsigned k);
        return BLOCK_WIDTH - (k + 1) * IO_WIDTH;
    endfunction

endpackage

// File: rtl/sm4_block_assembler.sv
// Pops IO_WIDTH-bit beats from the input FIFO, packs them MSB-first into 128-bit
// SM4 blocks tagged key/data, and flags framing errors (missing/early sof, tag change).
module sm4_block_assembler
    import sm4_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [ENTRY_W-1:0]     fifo_dout,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic [BLOCK_WIDTH-1:0] blk_data,
    output logic                   blk_is_key,
    output logic                   frame_err
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cap_cnt_q, cap_cnt_d;
    logic                   rd_pending_q;
    logic                   tag_q, tag_d;
    logic [BLOCK_WIDTH-1:0] buf_q, buf_d;
    logic [BLOCK_WIDTH-1:0] blk_data_q, blk_data_d;
    logic                   blk_valid_q, blk_valid_d;
    logic                   blk_is_key_q, blk_is_key_d;
    logic                   frame_err_q, frame_err_d;

    logic                   beat_sof;
    logic                   beat_key;
    logic [IO_WIDTH-1:0]    beat_payload;
    logic [CNT_W:0]         issued;
    logic                   wr_en;
    logic [CNT_W-1:0]       wr_idx;

    assign beat_sof     = fifo_dout[SOF_BIT];
    assign beat_key     = fifo_dout[KEY_BIT];
    assign beat_payload = fifo_dout[IO_WIDTH-1:0];

    // Captured plus in-flight beats; capping this at BEATS guarantees no pop is outstanding in OUT.
    assign issued     = {1'b0, cap_cnt_q} + {{CNT_W{1'b0}}, rd_pending_q};
    assign fifo_rd_en = (state_q == COLLECT) && !fifo_empty && (issued < (CNT_W + 1)'(BEATS));

    always_comb begin
        state_d      = state_q;
        cap_cnt_d    = cap_cnt_q;
        tag_d        = tag_q;
        buf_d        = buf_q;
        blk_data_d   = blk_data_q;
        blk_valid_d  = blk_valid_q;
        blk_is_key_d = blk_is_key_q;
        frame_err_d  = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = '0;

        if (rd_pending_q) begin
            if (beat_sof) begin
                wr_en       = 1'b1;
                tag_d       = beat_key;
                cap_cnt_d   = CNT_W'(1);
                frame_err_d = (cap_cnt_q != '0);
            end else if (cap_cnt_q == '0) begin
                frame_err_d = 1'b1;
            end else if (beat_key != tag_q) begin
                frame_err_d = 1'b1;
                cap_cnt_d   = '0;
            end else begin
                wr_en     = 1'b1;
                wr_idx    = cap_cnt_q;
                cap_cnt_d = cap_cnt_q + 1'b1;
            end
        end

        for (int unsigned s = 0; s < BEATS; s++) begin
            if (wr_en && (wr_idx == CNT_W'(s))) begin
                buf_d[slot_lsb(s) +: IO_WIDTH] = beat_payload;
            end
        end

        // Completion takes the merged buffer so the last beat appears in the same edge.
        if (wr_en && (cap_cnt_d == CNT_W'(BEATS))) begin
            blk_data_d   = buf_d;
            blk_is_key_d = tag_d;
            blk_valid_d  = 1'b1;
            state_d      = OUT;
            cap_cnt_d    = '0;
        end

        if ((state_q == OUT) && blk_valid_q && blk_ready) begin
            blk_valid_d = 1'b0;
            state_d     = COLLECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            cap_cnt_q    <= '0;
            rd_pending_q <= 1'b0;
            tag_q        <= 1'b0;
            buf_q        <= '0;
            blk_data_q   <= '0;
            blk_valid_q  <= 1'b0;
            blk_is_key_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cap_cnt_q    <= cap_cnt_d;
            rd_pending_q <= fifo_rd_en;
            tag_q        <= tag_d;
            buf_q        <= buf_d;
            blk_data_q   <= blk_data_d;
            blk_valid_q  <= blk_valid_d;
            blk_is_key_q <= blk_is_key_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign blk_valid  = blk_valid_q;
    assign blk_data   = blk_data_q;
    assign blk_is_key = blk_is_key_q;
    assign frame_err  = frame_err_q;

endmodule
